// File: rtl/multi_digit_watch_pkg.sv
// Shared types and constants for the multi-digit BCD stopwatch.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } watch_state_t;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned MOD6  = 6;
    localparam int unsigned MOD10 = 10;

    // Minutes/hours-style tens digits sit at odd indices 1 and 3.
    function automatic int unsigned digit_mod(input int unsigned idx, input bit sexa);
        if (sexa && (idx == 1 || idx == 3))
            return MOD6;
        return MOD10;
    endfunction

endpackage

// File: rtl/multi_digit_watch_if.sv
// Control/display bundle between the stopwatch and its user.
interface multi_digit_watch_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    start_resume;
    logic                    stop;
    logic                    lap;
    logic [4*NUM_DIGITS-1:0] number;
    logic                    cout;
    logic                    running;
    logic                    lap_active;

    modport master (
        output start_resume, stop, lap,
        input  number, cout, running, lap_active
    );

    modport slave (
        input  start_resume, stop, lap,
        output number, cout, running, lap_active
    );
endinterface

// File: rtl/multi_digit_watch_digit.sv
// One BCD digit counting modulo MOD; advances when inc is high.
module bcd_mod_digit
    import watch_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [BCD_W-1:0] value,
    output logic             at_max
);

    assign at_max = (value == BCD_W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (reset)
            value <= '0;
        else if (inc)
            value <= at_max ? '0 : value + 1'b1;
    end

endmodule

// File: rtl/multi_digit_watch.sv
// Multi-digit BCD stopwatch with prescaler, pause/resume, lap freeze and
// wrap-or-saturate overflow.
module multi_digit_watch
    import watch_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned SEXAGESIMAL = 0,
    parameter int unsigned WRAP        = 1
) (
    input  logic                clk,
    input  logic                reset,
    multi_digit_watch_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NW = BCD_W * NUM_DIGITS;

    watch_state_t state_q, state_d;

    logic [PW-1:0]         presc_q;
    logic [NW-1:0]         count;
    logic [NW-1:0]         hold_q;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] inc;
    logic                  full;
    logic                  tick;
    logic                  adv;
    logic                  lap_q;
    logic                  lap_rise;
    logic                  lap_active_q;
    logic                  cout_q;

    assign full     = &at_max;
    // stop outranks counting, so the edge that pauses does not also tick
    assign tick     = (state_q == RUN) && !bus.stop && (presc_q == PW'(TICK_DIV - 1));
    assign adv      = tick && !(full && (WRAP == 0));
    assign lap_rise = bus.lap && !lap_q;

    always_comb begin
        inc    = '0;
        inc[0] = adv;
        for (int unsigned i = 1; i < NUM_DIGITS; i++)
            inc[i] = inc[i-1] && at_max[i-1];
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_mod_digit #(
            .MOD(digit_mod(g, SEXAGESIMAL != 0))
        ) u_digit (
            .clk    (clk),
            .reset  (reset),
            .inc    (inc[g]),
            .value  (count[g*BCD_W +: BCD_W]),
            .at_max (at_max[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                if (bus.start_resume && !bus.stop)
                    state_d = RUN;
            RUN:
                if (bus.stop)
                    state_d = PAUSED;
                else if (tick && full && (WRAP == 0))
                    state_d = PAUSED;
            PAUSED:
                if (bus.start_resume && !bus.stop)
                    state_d = RUN;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            cout_q <= tick && full;
            if (state_q == RUN && !bus.stop)
                presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q        <= 1'b0;
            lap_active_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            lap_q <= bus.lap;
            if (lap_rise) begin
                if (lap_active_q) begin
                    lap_active_q <= 1'b0;
                end else if (state_q == RUN) begin
                    lap_active_q <= 1'b1;
                    hold_q       <= count;
                end
            end
        end
    end

    assign bus.number     = lap_active_q ? hold_q : count;
    assign bus.cout       = cout_q;
    assign bus.running    = (state_q == RUN);
    assign bus.lap_active = lap_active_q;

endmodule

// File: tb/tb_multi_digit_watch.sv
// Scoreboard bench: default watch, saturating watch, sexagesimal/divided watch.
module tb_multi_digit_watch;

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] e;

    always #5 clk = ~clk;

    multi_digit_watch_if #(.NUM_DIGITS(4)) bus_a ();
    multi_digit_watch_if #(.NUM_DIGITS(4)) bus_b ();
    multi_digit_watch_if #(.NUM_DIGITS(4)) bus_c ();

    multi_digit_watch dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    multi_digit_watch #(.WRAP(0)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
    multi_digit_watch #(.SEXAGESIMAL(1), .TICK_DIV(3)) dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.start_resume = 0; bus_a.stop = 0; bus_a.lap = 0;
        bus_b.start_resume = 0; bus_b.stop = 0; bus_b.lap = 0;
        bus_c.start_resume = 0; bus_c.stop = 0; bus_c.lap = 0;
        exp_q.push_back(16'h0000);
        step(5);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL reset_number got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", bus_a.cout); end
        checks++; if (bus_a.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus_a.running); end
        checks++; if (bus_a.lap_active !== 1'b0) begin failures++; $display("FAIL reset_lap got=%b exp=0", bus_a.lap_active); end
    endtask

    task automatic test_start;
        exp_q.push_back(16'h0012);
        bus_a.start_resume = 1'b1;
        step(1);
        bus_a.start_resume = 1'b0;
        step(12);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL start_number got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", bus_a.running); end
    endtask

    task automatic test_stop_resume;
        exp_q.push_back(16'h0025);
        exp_q.push_back(16'h0025);
        exp_q.push_back(16'h0030);
        step(13);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL pre_stop got=%h exp=%h", bus_a.number, e); end
        bus_a.stop = 1'b1;
        step(1);
        bus_a.stop = 1'b0;
        step(20);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL paused_hold got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.running !== 1'b0) begin failures++; $display("FAIL paused_running got=%b exp=0", bus_a.running); end
        bus_a.start_resume = 1'b1;
        step(1);
        bus_a.start_resume = 1'b0;
        step(5);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL resume got=%h exp=%h", bus_a.number, e); end
    endtask

    task automatic test_lap;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0050);
        exp_q.push_back(16'h0050);
        step(10);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL pre_lap got=%h exp=%h", bus_a.number, e); end
        bus_a.lap = 1'b1;
        step(1);
        bus_a.lap = 1'b0;
        step(9);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL lap_frozen got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.lap_active !== 1'b1) begin failures++; $display("FAIL lap_active got=%b exp=1", bus_a.lap_active); end
        // second lap coincides with stop: no tick, lap released
        bus_a.lap = 1'b1; bus_a.stop = 1'b1;
        step(1);
        bus_a.lap = 1'b0; bus_a.stop = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL lap_release got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.lap_active !== 1'b0) begin failures++; $display("FAIL lap_cleared got=%b exp=0", bus_a.lap_active); end
        step(1);
        bus_a.lap = 1'b1;
        step(1);
        bus_a.lap = 1'b0;
        step(1);
        e = exp_q.pop_front();
        checks++; if (bus_a.lap_active !== 1'b0) begin failures++; $display("FAIL lap_in_paused got=%b exp=0", bus_a.lap_active); end
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL lap_paused_num got=%h exp=%h", bus_a.number, e); end
    endtask

    task automatic test_wrap;
        int pulses;
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        rst_a = 1'b1; step(1); rst_a = 1'b0;
        bus_a.start_resume = 1'b1; step(1); bus_a.start_resume = 1'b0;
        step(9999);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL wrap_full got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.cout !== 1'b0) begin failures++; $display("FAIL wrap_cout_early got=%b exp=0", bus_a.cout); end
        step(1);
        e = exp_q.pop_front();
        checks++; if (bus_a.number !== e) begin failures++; $display("FAIL wrap_zero got=%h exp=%h", bus_a.number, e); end
        checks++; if (bus_a.cout !== 1'b1) begin failures++; $display("FAIL wrap_cout got=%b exp=1", bus_a.cout); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus_a.cout === 1'b1) pulses++;
            if (i == 0) begin
                e = exp_q.pop_front();
                checks++; if (bus_a.number !== e) begin failures++; $display("FAIL wrap_next got=%h exp=%h", bus_a.number, e); end
            end
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL wrap_cout_once got=%0d exp=0", pulses); end
    endtask

    task automatic test_saturate;
        int pulses;
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h9999);
        bus_b.start_resume = 1'b1; step(1); bus_b.start_resume = 1'b0;
        step(9999);
        e = exp_q.pop_front();
        checks++; if (bus_b.number !== e) begin failures++; $display("FAIL sat_full got=%h exp=%h", bus_b.number, e); end
        step(1);
        e = exp_q.pop_front();
        checks++; if (bus_b.number !== e) begin failures++; $display("FAIL sat_hold got=%h exp=%h", bus_b.number, e); end
        checks++; if (bus_b.cout !== 1'b1) begin failures++; $display("FAIL sat_cout got=%b exp=1", bus_b.cout); end
        checks++; if (bus_b.running !== 1'b0) begin failures++; $display("FAIL sat_running got=%b exp=0", bus_b.running); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus_b.cout === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL sat_cout_once got=%0d exp=0", pulses); end
        e = exp_q.pop_front();
        checks++; if (bus_b.number !== e) begin failures++; $display("FAIL sat_after got=%h exp=%h", bus_b.number, e); end
    endtask

    task automatic test_sexagesimal;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0102);
        bus_c.start_resume = 1'b1; step(1); bus_c.start_resume = 1'b0;
        step(180);
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL sexa_180 got=%h exp=%h", bus_c.number, e); end
        checks++; if (bus_c.running !== 1'b1) begin failures++; $display("FAIL sexa_running got=%b exp=1", bus_c.running); end
        step(2);
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL sexa_partial got=%h exp=%h", bus_c.number, e); end
        step(1);
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL sexa_tick got=%h exp=%h", bus_c.number, e); end
        // pause one edge into a period; resume must finish the remaining two
        step(1);
        bus_c.stop = 1'b1; step(1); bus_c.stop = 1'b0;
        bus_c.start_resume = 1'b1; step(1); bus_c.start_resume = 1'b0;
        step(1);
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL presc_hold got=%h exp=%h", bus_c.number, e); end
        step(1);
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL presc_resume got=%h exp=%h", bus_c.number, e); end
    endtask

    task automatic test_reset_mid_run;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        bus_c.lap = 1'b1; step(1); bus_c.lap = 1'b0;
        step(4);
        rst_c = 1'b1; step(1); rst_c = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL rst_run_number got=%h exp=%h", bus_c.number, e); end
        checks++; if (bus_c.running !== 1'b0) begin failures++; $display("FAIL rst_run_running got=%b exp=0", bus_c.running); end
        checks++; if (bus_c.lap_active !== 1'b0) begin failures++; $display("FAIL rst_run_lap got=%b exp=0", bus_c.lap_active); end
        checks++; if (bus_c.cout !== 1'b0) begin failures++; $display("FAIL rst_run_cout got=%b exp=0", bus_c.cout); end
        step(9);
        e = exp_q.pop_front();
        checks++; if (bus_c.number !== e) begin failures++; $display("FAIL rst_no_restart got=%h exp=%h", bus_c.number, e); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop_resume();
        test_lap();
        test_wrap();
        test_saturate();
        test_sexagesimal();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_digit_watch.md
MULTI_DIGIT_WATCH -- requirements
Module: multi_digit_watch

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits, legal 1..8.
REQ-002 Parameter TICK_DIV, default 1: clk cycles per count tick, legal 1..2^24.
REQ-003 Parameter SEXAGESIMAL, default 0: 1 = digits at index 1 and 3 count mod 6, all others mod 10; 0 = all digits mod 10.
REQ-004 Parameter WRAP, default 1: 1 = wrap to zero on full-scale overflow; 0 = saturate at full scale.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start_resume  input  1  level-sampled start/resume request.
REQ-008 stop  input  1  level-sampled pause request.
REQ-009 lap  input  1  lap/split request; the block detects its rising edge.
REQ-010 number  output  4*NUM_DIGITS  displayed BCD value; digit 0 in bits [3:0].
REQ-011 cout  output  1  one-cycle full-scale overflow pulse.
REQ-012 running  output  1  high while in state RUN.
REQ-013 lap_active  output  1  high while the display is frozen by a lap.

Function
REQ-014 States: IDLE (zero, not counting), RUN, PAUSED; all outputs registered.
REQ-015 Input priority each edge: reset > stop > start_resume > lap.
REQ-016 IDLE or PAUSED with start_resume=1 and stop=0 -> RUN on that edge; RUN with stop=1 -> PAUSED; start_resume held in RUN has no effect.
REQ-017 Prescaler counts 0..TICK_DIV-1 only in RUN; a tick occurs on the edge where the prescaler equals TICK_DIV-1, and the prescaler then returns to 0; the first tick occurs TICK_DIV edges after entry to RUN.
REQ-018 Prescaler holds its value in PAUSED, so resume continues the partial period.
REQ-019 On a tick, digit 0 increments; digit i increments iff every lower digit is at its max; a digit at max rolls to 0; the ripple completes within the same edge.
REQ-020 Full scale = every digit at max; a tick at full scale with WRAP=1 sets all digits to 0 and cout=1 for exactly that one cycle.
REQ-021 A tick at full scale with WRAP=0 holds all digits at max, pulses cout for one cycle, and moves to PAUSED.
REQ-022 Internal count updates on the tick edge; number equals the internal count whenever lap_active=0.
REQ-023 In RUN, a lap rising edge with lap_active=0 captures the current count into a hold register and sets lap_active; number shows the hold value while counting continues.
REQ-024 A lap rising edge with lap_active=1 clears lap_active in any state; number returns to the live count on the next cycle.
REQ-025 A lap rising edge in IDLE or PAUSED with lap_active=0 is ignored.
REQ-026 stop does not clear lap_active.
REQ-027 start_resume and stop both high -> stop wins, and the state becomes or stays PAUSED (IDLE stays IDLE).

Reset
REQ-028 reset=1 on an edge forces: state IDLE, count and hold register 0, prescaler 0, lap edge detector 0, number=0, cout=0, running=0, lap_active=0.
REQ-029 reset mid-RUN or mid-lap takes effect on that same edge, and pending ticks are discarded.
REQ-030 Counting resumes only on a new start_resume after reset deasserts.

Structure
REQ-031 Shared package watch_pkg holds the state enum (IDLE/RUN/PAUSED), BCD_W=4, and the mod-6/mod-10 constants.
REQ-032 One sub-module bcd_mod_digit, instantiated NUM_DIGITS times, with inputs clk, reset, inc, and parameter MOD, and outputs value and at_max.

Verification
REQ-033 Defaults (4 digits, TICK_DIV=1, SEXAGESIMAL=0, WRAP=1). reset high for 5 cycles -> number=16'h0000, cout=0, running=0, lap_active=0.
REQ-034 start_resume pulsed for 1 cycle, then 12 edges -> number=16'h0012, running=1.
REQ-035 Run for 9999 ticks -> number=16'h9999; next tick -> number=16'h0000 with cout=1 for one cycle only. With WRAP=0, the same tick leaves number=16'h9999, running=0, and cout pulsed once.
REQ-036 stop at count 16'h0025, idle 20 cycles -> number stays 16'h0025. Then start_resume, 5 ticks -> 16'h0030.
REQ-037 lap at count 16'h0040, 10 ticks -> number=16'h0040, lap_active=1. Second lap -> number=16'h0050 next cycle.
REQ-038 SEXAGESIMAL=1, TICK_DIV=3: 180 edges after start -> number=16'h0100. Also assert reset during RUN -> all outputs 0 on the next cycle.
